// File: rtl/i2s_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2s_pkg: shared sample type and frame constants for the I2S transmit path.
// Rev 1.0
// ----------------------------------------------------------------------------
package i2s_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int FRAME_SCLK = 48;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage : i2s_pkg
`default_nettype wire

// File: rtl/i2s_sample_feeder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2s_sample_feeder_if: valid/ready sample stream from producer to feeder.
// Rev 1.0
// ----------------------------------------------------------------------------
interface i2s_sample_feeder_if
  import i2s_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W
) ();

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );

endinterface : i2s_sample_feeder_if
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sample_fifo: synchronous show-ahead FIFO with a separately tracked level.
// Rev 1.0
// ----------------------------------------------------------------------------
module sample_fifo
  import i2s_pkg::*;
#(
  parameter  int DATA_W  = SAMPLE_W,
  parameter  int DEPTH   = 16,
  localparam int AW      = $clog2(DEPTH),
  localparam int LEVEL_W = $clog2(DEPTH + 1)
) (
  input  wire logic               clk_i2s,
  input  wire logic               reset_n,
  input  wire logic               push,
  input  wire logic               pop,
  input  wire logic [DATA_W-1:0]  wdata,
  output logic      [DATA_W-1:0]  rdata,
  output logic                    full,
  output logic                    empty,
  output logic      [LEVEL_W-1:0] level
);

  localparam logic [LEVEL_W-1:0] C_FULL_LEVEL = LEVEL_W'(DEPTH);

  logic [DATA_W-1:0]  r_mem [0:DEPTH-1];
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [LEVEL_W-1:0] r_level;

  logic w_do_push;
  logic w_do_pop;

  assign full      = (r_level == C_FULL_LEVEL);
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign rdata     = r_mem[r_rptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Storage is not reset; only pointers and level define validity.
  always_ff @(posedge clk_i2s) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  always_ff @(posedge clk_i2s) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule : sample_fifo
`default_nettype wire

// File: rtl/i2s_sample_feeder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2s_sample_feeder: buffers PCM samples and presents one per frame on tx_data.
// Rev 1.0
// ----------------------------------------------------------------------------
module i2s_sample_feeder
  import i2s_pkg::*;
#(
  parameter  int DATA_W         = SAMPLE_W,
  parameter  int DEPTH          = 16,
  parameter  bit UNDERFLOW_ZERO = 1'b1,
  localparam int LEVEL_W        = $clog2(DEPTH + 1)
) (
  input  wire logic                clk_i2s,
  input  wire logic                reset_n,
  i2s_sample_feeder_if.slave       s_if,
  input  wire logic                lrclk,
  input  wire logic                mute,
  output logic      [DATA_W-1:0]   tx_data,
  output logic                     frame_tick,
  output logic                     underflow,
  output logic      [LEVEL_W-1:0]  level
);

  logic               r_lrclk_q;
  logic [DATA_W-1:0]  r_tx_data;
  logic               r_frame_tick;
  logic               r_underflow;

  logic               w_adv;
  logic               w_push;
  logic               w_full;
  logic               w_empty;
  logic [DATA_W-1:0]  w_head;
  logic [LEVEL_W-1:0] w_level;

  assign s_if.s_ready = !w_full;
  assign w_push       = s_if.s_valid && !w_full;
  // Advance on lrclk rising edge (mid-frame) so tx_data settles before the next load.
  assign w_adv        = lrclk && !r_lrclk_q;

  sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i2s (clk_i2s),
    .reset_n (reset_n),
    .push    (w_push),
    .pop     (w_adv),
    .wdata   (s_if.s_data),
    .rdata   (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .level   (w_level)
  );

  always_ff @(posedge clk_i2s) begin
    if (!reset_n) begin
      r_lrclk_q    <= 1'b0;
      r_tx_data    <= '0;
      r_frame_tick <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_lrclk_q    <= lrclk;
      r_frame_tick <= w_adv;
      r_underflow  <= w_adv && w_empty;
      if (w_adv) begin
        if (!w_empty) begin
          r_tx_data <= mute ? '0 : w_head;
        end else if (UNDERFLOW_ZERO || mute) begin
          r_tx_data <= '0;
        end
      end
    end
  end

  assign tx_data    = r_tx_data;
  assign frame_tick = r_frame_tick;
  assign underflow  = r_underflow;
  assign level      = w_level;

endmodule : i2s_sample_feeder
`default_nettype wire
